// File: rtl/nn_pkg.sv
// Shared fixed-point definitions for the digit-recognition neuron layers:
// default Q-format widths, accumulator sizing and the ReLU/saturation stage.
package nn_pkg;

   localparam int DATA_W    = 16;
   localparam int FRAC_BITS = 8;
   localparam int ACC_MAX   = 64;

   typedef logic signed [DATA_W-1:0] q_t;

   localparam q_t Q_MAX = q_t'({1'b0, {(DATA_W-1){1'b1}}});

   function automatic int accWidth(input int dataW, input int numW);
      return 2 * dataW + $clog2(numW);
   endfunction

   // Negative sums clip to zero; positive sums drop the extra fraction and clamp.
   function automatic q_t relu_sat(input logic signed [ACC_MAX-1:0] acc, input int fracB);
      logic signed [ACC_MAX-1:0] scaled;
      scaled = acc >>> fracB;
      if (acc[ACC_MAX-1]) return '0;
      if (scaled > ACC_MAX'(Q_MAX)) return Q_MAX;
      return q_t'(scaled);
   endfunction

endpackage

// File: rtl/weight_mem.sv
// Per-neuron weight store: one write port, one registered read port (1-cycle latency).
module weight_mem #(
   parameter int depth = 10,
   parameter int width = 16,
   parameter int addrW = 4
) (
   input  logic                    clk,
   input  logic                    writeEn,
   input  logic [addrW-1:0]        writeAddr,
   input  logic signed [width-1:0] writeData,
   input  logic                    readEn,
   input  logic [addrW-1:0]        readAddr,
   output logic signed [width-1:0] readData
);

   logic signed [width-1:0] mem [depth];

   always_ff @(posedge clk) begin
      if (writeEn) mem[writeAddr] <= writeData;
      if (readEn) readData <= mem[readAddr];
   end

endmodule

// File: rtl/neuron_mac.sv
// Streaming fixed-point neuron: weight multiply, accumulate, bias, ReLU with
// saturation. Five register stages; valid tokens flow every cycle, data only on valid.
module neuron_mac
   import nn_pkg::*;
#(
   parameter int numWeight = 10,
   parameter int dataWidth = DATA_W,
   parameter int fracBits  = FRAC_BITS
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         weightValid,
   input  logic [$clog2(numWeight)-1:0] weightAddr,
   input  logic signed [dataWidth-1:0]  weightIn,
   input  logic                         biasValid,
   input  logic signed [dataWidth-1:0]  biasIn,
   input  logic signed [dataWidth-1:0]  inData,
   input  logic                         inValid,
   output logic [dataWidth-1:0]         outData,
   output logic                         outValid,
   output logic                         busy
);

   localparam int addrW = $clog2(numWeight);
   localparam int accW  = accWidth(dataWidth, numWeight);
   localparam int prodW = 2 * dataWidth;

   logic [addrW-1:0]            idxReg;
   logic                        idxLast;
   logic                        s0Valid, s0First, s0Last;
   logic signed [dataWidth-1:0] s0Data, rdWeight, biasReg;
   logic                        s1Valid, s1First, s1Last;
   logic signed [prodW-1:0]     prodReg;
   logic                        s2Valid, s2Last;
   logic signed [accW-1:0]      accReg, sumReg;
   logic                        s3Valid;
   logic [dataWidth-1:0]        outDataReg;
   logic                        outValidReg;
   logic                        busyInt, writeOk;

   assign idxLast = (idxReg == addrW'(numWeight - 1));
   assign busyInt = (idxReg != '0) || s0Valid || s1Valid || s2Valid || s3Valid;
   // Reset wins over a coincident write strobe.
   assign writeOk = !busyInt && !rst;

   weight_mem #(.depth(numWeight), .width(dataWidth), .addrW(addrW)) uWeightMem (
      .clk       (clk),
      .writeEn   (weightValid && writeOk),
      .writeAddr (weightAddr),
      .writeData (weightIn),
      .readEn    (inValid),
      .readAddr  (idxReg),
      .readData  (rdWeight)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         idxReg  <= '0;
         s0Valid <= 1'b0;
         s0First <= 1'b0;
         s0Last  <= 1'b0;
         s0Data  <= '0;
      end else begin
         s0Valid <= inValid;
         if (inValid) begin
            s0Data  <= inData;
            s0First <= (idxReg == '0);
            s0Last  <= idxLast;
            idxReg  <= idxLast ? '0 : idxReg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1Valid     <= 1'b0;
         s1First     <= 1'b0;
         s1Last      <= 1'b0;
         prodReg     <= '0;
         s2Valid     <= 1'b0;
         s2Last      <= 1'b0;
         accReg      <= '0;
         s3Valid     <= 1'b0;
         sumReg      <= '0;
         outValidReg <= 1'b0;
         outDataReg  <= '0;
      end else begin
         s1Valid <= s0Valid;
         if (s0Valid) begin
            prodReg <= s0Data * rdWeight;
            s1First <= s0First;
            s1Last  <= s0Last;
         end
         // The first tag reloads instead of adding, so images may abut with no bubble.
         s2Valid <= s1Valid;
         if (s1Valid) begin
            accReg <= s1First ? accW'(prodReg) : accReg + accW'(prodReg);
            s2Last <= s1Last;
         end
         s3Valid <= s2Valid && s2Last;
         if (s2Valid && s2Last) sumReg <= accReg + (accW'(biasReg) <<< fracBits);
         outValidReg <= s3Valid;
         if (s3Valid) outDataReg <= dataWidth'(relu_sat(ACC_MAX'(sumReg), fracBits));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) biasReg <= '0;
      else if (biasValid && !busyInt) biasReg <= biasIn;
   end

   assign outData  = outDataReg;
   assign outValid = outValidReg;
   assign busy     = busyInt;

endmodule

// File: tb/tb_neuron_mac.sv
// Randomized self-checking bench for neuron_mac (numWeight=4, Q8.8) against an
// arithmetic reference of the neuron's transfer function and pulse timing.
module tb_neuron_mac;

   localparam int NW = 4;

   logic               clk = 1'b0;
   logic               rst, weightValid, biasValid, inValid;
   logic [1:0]         weightAddr;
   logic signed [15:0] weightIn, biasIn, inData;
   logic [15:0]        outData;
   logic               outValid, busy;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int pulseVal[$];
   int pulseCyc[$];
   int modelW[NW];
   int modelBias = 0;

   neuron_mac #(.numWeight(NW), .dataWidth(16), .fracBits(8)) dut (
      .clk(clk), .rst(rst), .weightValid(weightValid), .weightAddr(weightAddr),
      .weightIn(weightIn), .biasValid(biasValid), .biasIn(biasIn), .inData(inData),
      .inValid(inValid), .outData(outData), .outValid(outValid), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (outValid === 1'b1) begin
         pulseVal.push_back(int'(outData));
         pulseCyc.push_back(cyc);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at time limit");
      $fatal(1);
   end

   // Neuron output from the plain arithmetic definition: dot product plus
   // bias scaled to Q-format, clipped at zero, truncated back to Q8.8, clamped.
   function automatic int ref_result(input int ins[NW]);
      longint s = 0;
      for (int i = 0; i < NW; i++) s += longint'(ins[i]) * longint'(modelW[i]);
      s += longint'(modelBias) * 256;
      if (s < 0) return 0;
      if (s / 256 > 32767) return 32767;
      return int'(s / 256);
   endfunction

   task automatic load(input int w[NW], input int b);
      for (int i = 0; i < NW; i++) begin
         weightValid = 1'b1; weightAddr = 2'(i); weightIn = 16'(w[i]);
         @(negedge clk);
         modelW[i] = w[i];
      end
      weightValid = 1'b0;
      biasValid = 1'b1; biasIn = 16'(b);
      @(negedge clk);
      biasValid = 1'b0;
      modelBias = b;
   endtask

   task automatic send(input int d, input int gapMax, output int edgeN);
      int g = int'($urandom_range(gapMax, 0));
      inValid = 1'b0;
      repeat (g) @(negedge clk);
      inData = 16'(d); inValid = 1'b1; edgeN = cyc + 1;
      @(negedge clk);
      inValid = 1'b0;
   endtask

   task automatic run_image(input int ins[NW], input int gapMax, output int lastEdge);
      for (int i = 0; i < NW; i++) send(ins[i], gapMax, lastEdge);
   endtask

   task automatic collect(input int n);
      int budget = 60;
      while (pulseVal.size() < n && budget > 0) begin @(negedge clk); #1; budget--; end
      repeat (6) begin @(negedge clk); #1; end
   endtask

   task automatic test_reset();
      rst = 1'b1; weightValid = 1'b0; biasValid = 1'b0; inValid = 1'b0;
      weightAddr = '0; weightIn = '0; biasIn = '0; inData = '0;
      repeat (3) @(negedge clk);
      checks++; if (outData !== 16'd0) begin errors++; $display("FAIL reset_outData: got %0d want 0", outData); end
      checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid: got %b want 0", outValid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      rst = 1'b0; modelBias = 0;
      @(negedge clk);
      $display("reset: outData=%0d outValid=%b busy=%b", outData, outValid, busy);
   endtask

   // One-image scenario: load, send, then check value, timing, pulse count, busy.
   task automatic test_single(input string name, input int w[NW], input int b, input int x[NW]);
      int le, expv;
      pulseVal.delete(); pulseCyc.delete();
      load(w, b);
      expv = ref_result(x);
      run_image(x, 0, le);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy_inflight: got %b want 1", name, busy); end
      collect(1);
      checks++; if (pulseVal.size() != 1) begin errors++; $display("FAIL %s_pulse_count: got %0d want 1", name, pulseVal.size()); end
      if (pulseVal.size() >= 1) begin
         $display("%s: outData=%0d expected=%0d pulse cycle=%0d expected=%0d", name, pulseVal[0], expv, pulseCyc[0], le + 4);
         checks++; if (pulseVal[0] != expv) begin errors++; $display("FAIL %s_value: got %0d want %0d", name, pulseVal[0], expv); end
         checks++; if (pulseCyc[0] != le + 4) begin errors++; $display("FAIL %s_latency: got cycle %0d want %0d", name, pulseCyc[0], le + 4); end
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_idle: got %b want 0", name, busy); end
      checks++; if (int'(outData) != expv) begin errors++; $display("FAIL %s_hold: got %0d want %0d", name, outData, expv); end
   endtask

   task automatic test_back_to_back();
      int w[NW] = '{256, 256, 256, 256};
      int a[NW] = '{256, 256, 256, 256};
      int bImg[NW] = '{512, 512, 512, 512};
      int leA, leB, expA, expB;
      pulseVal.delete(); pulseCyc.delete();
      load(w, 384);
      expA = ref_result(a); expB = ref_result(bImg);
      run_image(a, 2, leA);
      run_image(bImg, 0, leB);
      collect(2);
      checks++; if (pulseVal.size() != 2) begin errors++; $display("FAIL b2b_pulse_count: got %0d want 2", pulseVal.size()); end
      if (pulseVal.size() >= 2) begin
         $display("b2b: A=%0d (exp %0d) B=%0d (exp %0d)", pulseVal[0], expA, pulseVal[1], expB);
         checks++; if (pulseVal[0] != expA) begin errors++; $display("FAIL b2b_imageA: got %0d want %0d", pulseVal[0], expA); end
         checks++; if (pulseVal[1] != expB) begin errors++; $display("FAIL b2b_imageB: got %0d want %0d", pulseVal[1], expB); end
         checks++; if (pulseCyc[0] != leA + 4) begin errors++; $display("FAIL b2b_latencyA: got %0d want %0d", pulseCyc[0], leA + 4); end
         checks++; if (pulseCyc[1] != leB + 4) begin errors++; $display("FAIL b2b_latencyB: got %0d want %0d", pulseCyc[1], leB + 4); end
      end
   endtask

   task automatic test_reset_mid();
      int w[NW] = '{256, 256, 256, 256};
      int x[NW] = '{256, 256, 256, 256};
      int le, expv;
      pulseVal.delete(); pulseCyc.delete();
      load(w, 0);
      send(300, 0, le);
      send(300, 0, le);
      rst = 1'b1; weightValid = 1'b1; weightAddr = 2'd0; weightIn = 16'sd0;
      @(negedge clk);
      rst = 1'b0; weightValid = 1'b0; modelBias = 0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      expv = ref_result(x);
      run_image(x, 1, le);
      collect(1);
      checks++; if (pulseVal.size() != 1) begin errors++; $display("FAIL rstmid_pulse_count: got %0d want 1", pulseVal.size()); end
      if (pulseVal.size() >= 1) begin
         $display("rstmid: outData=%0d expected=%0d", pulseVal[0], expv);
         checks++; if (pulseVal[0] != expv) begin errors++; $display("FAIL rstmid_value: got %0d want %0d", pulseVal[0], expv); end
         checks++; if (pulseCyc[0] != le + 4) begin errors++; $display("FAIL rstmid_latency: got %0d want %0d", pulseCyc[0], le + 4); end
      end
   endtask

   task automatic test_write_blocked();
      int w[NW] = '{256, 256, 256, 256};
      int x[NW] = '{256, 256, 256, 256};
      int le, exp1, exp2;
      pulseVal.delete(); pulseCyc.delete();
      load(w, 0);
      exp1 = ref_result(x);
      send(256, 0, le);
      send(256, 0, le);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wrblk_busy: got %b want 1", busy); end
      weightValid = 1'b1; weightAddr = 2'd0; weightIn = 16'sd0;
      biasValid = 1'b1; biasIn = 16'sd1000;
      @(negedge clk);
      weightValid = 1'b0; biasValid = 1'b0;
      send(256, 0, le);
      send(256, 0, le);
      run_image(x, 0, le);
      collect(2);
      checks++; if (pulseVal.size() != 2) begin errors++; $display("FAIL wrblk_pulse_count: got %0d want 2", pulseVal.size()); end
      for (int i = 0; i < pulseVal.size() && i < 2; i++) begin
         $display("wrblk image %0d: outData=%0d expected=%0d", i, pulseVal[i], exp1);
         checks++; if (pulseVal[i] != exp1) begin errors++; $display("FAIL wrblk_value%0d: got %0d want %0d", i, pulseVal[i], exp1); end
      end
      pulseVal.delete(); pulseCyc.delete();
      weightValid = 1'b1; weightAddr = 2'd0; weightIn = 16'sd0;
      @(negedge clk);
      weightValid = 1'b0; modelW[0] = 0;
      exp2 = ref_result(x);
      run_image(x, 0, le);
      collect(1);
      checks++; if (pulseVal.size() != 1) begin errors++; $display("FAIL wridle_pulse_count: got %0d want 1", pulseVal.size()); end
      if (pulseVal.size() >= 1) begin
         $display("wridle: outData=%0d expected=%0d", pulseVal[0], exp2);
         checks++; if (pulseVal[0] != exp2) begin errors++; $display("FAIL wridle_value: got %0d want %0d", pulseVal[0], exp2); end
      end
   endtask

   task automatic test_random(input int wRange, input int xRange, input int bRange);
      int w[NW], x[NW], le, b;
      int expQ[$], edgeQ[$];
      pulseVal.delete(); pulseCyc.delete();
      for (int i = 0; i < NW; i++) w[i] = int'($urandom_range(2 * wRange, 0)) - wRange;
      b = int'($urandom_range(2 * bRange, 0)) - bRange;
      load(w, b);
      for (int n = 0; n < 5; n++) begin
         for (int i = 0; i < NW; i++) x[i] = int'($urandom_range(2 * xRange, 0)) - xRange;
         expQ.push_back(ref_result(x));
         run_image(x, 2, le);
         edgeQ.push_back(le + 4);
      end
      collect(5);
      checks++; if (pulseVal.size() != 5) begin errors++; $display("FAIL rand_pulse_count: got %0d want 5", pulseVal.size()); end
      for (int n = 0; n < pulseVal.size() && n < 5; n++) begin
         $display("rand image %0d: outData=%0d expected=%0d cycle=%0d expected=%0d", n, pulseVal[n], expQ[n], pulseCyc[n], edgeQ[n]);
         checks++; if (pulseVal[n] != expQ[n]) begin errors++; $display("FAIL rand_value%0d: got %0d want %0d", n, pulseVal[n], expQ[n]); end
         checks++; if (pulseCyc[n] != edgeQ[n]) begin errors++; $display("FAIL rand_latency%0d: got %0d want %0d", n, pulseCyc[n], edgeQ[n]); end
      end
   endtask

   initial begin
      int wPos[NW] = '{256, 256, 256, 256};
      int wNeg[NW] = '{-256, -256, -256, -256};
      int wMax[NW] = '{32767, 32767, 32767, 32767};
      int xRamp[NW] = '{256, 512, 768, 1024};
      int xOne[NW] = '{256, 256, 256, 256};
      test_reset();
      test_single("basic", wPos, 0, xRamp);
      test_single("negative", wNeg, 0, xOne);
      test_single("saturate", wMax, 32767, wMax);
      test_back_to_back();
      test_reset_mid();
      test_write_blocked();
      test_random(512, 1024, 2000);
      test_random(2048, 4096, 8000);
      test_random(32767, 32767, 32767);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Single fixed-point neuron for the final (and hidden) layers of the digit-recognition network: streams one activation per valid cycle, multiplies by a locally stored weight, accumulates, adds bias, applies ReLU with saturation, and emits one `dataWidth` result per image. `numInput` instances run in lockstep inside a layer. Their `outData` words are concatenated, and their common `outValid` drives the arg-max stage's `inValid`.

## Interface
- `numWeight`, default 10: inputs (and weights) per neuron.
- `dataWidth`, default 16: signed width of activations, weights, bias and output.
- `fracBits`, default 8: fractional bits of every Q-format value (1.0 = 2^fracBits).
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `weightValid`  in  1  write strobe for weight memory.
- `weightAddr`  in  $clog2(numWeight)  weight index.
- `weightIn`  in  dataWidth  signed weight.
- `biasValid`  in  1  write strobe for bias register.
- `biasIn`  in  dataWidth  signed bias.
- `inData`  in  dataWidth  signed input activation.
- `inValid`  in  1  `inData` is valid this cycle.
- `outData`  out  dataWidth  activated result (always ≥ 0).
- `outValid`  out  1  one-cycle pulse; `outData` is valid.
- `busy`  out  1  high while any input of an image is in flight.

## Operation
- Input counter `idx` runs from 0 to numWeight-1. It advances on each `inValid`, wraps to 0 after the last input, and tags that input `last`. Gaps, where `inValid` is low, are allowed anywhere and freeze the pipeline contents without corrupting them.
- Pipeline stages:
  - S0: register `inData`, issue the weight read at `idx`, and tag `first` when idx==0 and `last` when idx==numWeight-1.
  - S1: signed product, 2·dataWidth bits.
  - S2: accumulator of width accW = 2·dataWidth + $clog2(numWeight). It loads the product when tagged `first` and adds it otherwise. It never overflows and never saturates.
  - S3: on `last`, add bias sign-extended and shifted left by fracBits.
  - S4: activation. A negative sum gives 0. Otherwise the sum is shifted right arithmetically by fracBits and clamped to 2^(dataWidth-1)-1. The result is registered to `outData` with `outValid`=1.
- Back-to-back images: the first input of image N+1 may arrive the cycle after the last input of image N. The `first` tag restarts the accumulator with no bubble and no cross-image leakage.
- Weight and bias writes are accepted only when `busy`=0 and are silently dropped otherwise. A write takes effect for the next image. Weight read-during-write is not possible because writes are blocked when busy.
- `busy` = (idx≠0) OR any stage S0–S3 holds a valid token.
- `outData` holds its value between pulses.

## Timing
- Latency: if the numWeight-th input is sampled at edge L, `outValid` is high for exactly the cycle after edge L+4.
- Throughput: one input per cycle, giving one result per numWeight cycles when inputs are back-to-back.
- Reset values: `outData`=0, `outValid`=0, `busy`=0, idx=0, all stage valids=0, accumulator=0, bias=0. Weight memory contents are not cleared.
- Reset mid-image discards the partial sum and all in-flight tokens. No `outValid` is produced for the aborted image. The next `inValid` after reset is treated as idx 0.
- `rst` has priority over all strobes in the same cycle.
- Simultaneous `weightValid` and `biasValid` while idle are both accepted.

## Structure
- Package `nn_pkg` holds:
  - default `dataWidth` and `fracBits` constants;
  - `accW` computation;
  - function `relu_sat(acc)` returning a dataWidth result;
  - Q-format typedef `q_t` (logic signed [dataWidth-1:0]).
- Sub-module `weight_mem`: numWeight × dataWidth, one write port and one synchronous read port with 1-cycle read latency, inferring distributed/block RAM.

## Test plan
All scenarios use numWeight=4, dataWidth=16, fracBits=8.
- Weights all 256, bias 0, inputs 256, 512, 768, 1024 back-to-back: `outData`=2560, a single `outValid` 4 cycles after the last input.
- Weights all -256, bias 0, inputs 256 ×4: sum is -1024, so `outData`=0 with `outValid` pulsed.
- Weights 32767 ×4, inputs 32767 ×4, bias 32767: `outData` clamps to 32767.
- Weights 256, bias 384: image A (256 ×4) with random `inValid` gaps, immediately followed by image B (512 ×4). Results are 1408 then 2432, with no leakage between images.
- Reset after 2 inputs of an image, then a full image of 256 ×4 (weights 256, bias 0): no pulse for the aborted image, then `outData`=1024.
- `weightValid` with weight 0 at addr 0 while `busy`=1: the write is dropped and the current and next results are unchanged. The same write when idle makes the next result with inputs 256 ×4 equal 768.
